// File: rtl/sym_frame_enc.sv
// Bit-serial VLC transmit framer: PREAMBLE, SFD, PHR, PSDU, FCS sent LSB-first, one bit per BIT_CLKS clocks.
// Optional abort input is enabled by defining SYM_ENC_ABORT_EN.

`ifndef SYM_ENC_DEC_PREAMBLE
`define SYM_ENC_DEC_PREAMBLE 8'h55
`endif
`ifndef SYM_ENC_DEC_SFD
`define SYM_ENC_DEC_SFD 8'hA7
`endif

module sym_frame_enc #(
  parameter logic [15:0] BIT_CLKS = 16'd80,
  parameter logic [7:0]  PREAMBLE = `SYM_ENC_DEC_PREAMBLE,
  parameter logic [7:0]  SFD      = `SYM_ENC_DEC_SFD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [6:0] i_len,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
`ifdef SYM_ENC_ABORT_EN
  input  logic       i_abort,
`endif
  output logic       o_byte_ready,
  output logic       o_bit,
  output logic       o_bit_tick,
  output logic       o_tx_active,
  output logic [2:0] o_ev,
  output logic       o_ev_sig
);

  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_PREAMBLE = 3'd1;
  localparam logic [2:0] EV_SFD      = 3'd2;
  localparam logic [2:0] EV_BYTE     = 3'd3;
  localparam logic [2:0] EV_COMPLETE = 3'd4;
  localparam logic [2:0] EV_ERROR    = 3'd5;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PHR, S_PSDU, S_FCS, S_DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] clk_cnt_reg;
  logic [3:0]  idx_reg;
  logic [6:0]  len_reg;
  logic [6:0]  owed_reg;
  logic [7:0]  hold_reg;
  logic        hold_full_reg;
  logic [7:0]  cur_reg;
  logic [15:0] crc_reg;
  logic [15:0] fcs_reg;
  logic        bit_reg;
  logic        tick_reg;
  logic        active_reg;
  logic [2:0]  ev_reg;
  logic        ev_sig_reg;

  logic        abort;
  logic        bit_last;
  logic [3:0]  last_idx;
  logic [3:0]  idx_inc;
  logic        ready;
  logic        take;
  logic        next_bit;
  logic [7:0]  phr_word;
  logic [15:0] crc_next;

`ifdef SYM_ENC_ABORT_EN
  assign abort = i_abort && (state_reg != S_IDLE);
`else
  assign abort = 1'b0;
`endif

  assign bit_last = (clk_cnt_reg == BIT_CLKS - 16'd1);
  assign last_idx = (state_reg == S_FCS) ? 4'd15 : 4'd7;
  assign idx_inc  = idx_reg + 4'd1;
  assign phr_word = {1'b0, len_reg};
  assign ready    = ((state_reg == S_PHR) || (state_reg == S_PSDU)) &&
                    !hold_full_reg && (owed_reg != 7'd0) && !abort;
  assign take     = ready && i_byte_valid;
  // Serial CRC-16/CCITT, MSB-first register, one line bit per step.
  assign crc_next = {crc_reg[14:0], 1'b0} ^ ((crc_reg[15] ^ bit_reg) ? CRC_POLY : 16'h0000);

  // Value of the following bit within the current field.
  always_comb begin
    next_bit = 1'b0;
    case (state_reg)
      S_PRE:   next_bit = PREAMBLE[idx_inc[2:0]];
      S_SFD:   next_bit = SFD[idx_inc[2:0]];
      S_PHR:   next_bit = phr_word[idx_inc[2:0]];
      S_PSDU:  next_bit = cur_reg[idx_inc[2:0]];
      S_FCS:   next_bit = fcs_reg[idx_inc];
      default: next_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      clk_cnt_reg   <= 16'd0;
      idx_reg       <= 4'd0;
      len_reg       <= 7'd0;
      owed_reg      <= 7'd0;
      hold_reg      <= 8'd0;
      hold_full_reg <= 1'b0;
      cur_reg       <= 8'd0;
      crc_reg       <= 16'd0;
      fcs_reg       <= 16'd0;
      bit_reg       <= 1'b0;
      tick_reg      <= 1'b0;
      active_reg    <= 1'b0;
      ev_reg        <= EV_NONE;
      ev_sig_reg    <= 1'b0;
    end else begin
      tick_reg   <= 1'b0;
      ev_sig_reg <= 1'b0;

      if (take) begin
        hold_reg      <= i_byte;
        hold_full_reg <= 1'b1;
        owed_reg      <= owed_reg - 7'd1;
      end

      if ((state_reg == S_PSDU) && tick_reg) begin
        crc_reg <= crc_next;
      end

      if (abort) begin
        state_reg     <= S_IDLE;
        active_reg    <= 1'b0;
        bit_reg       <= 1'b0;
        hold_full_reg <= 1'b0;
        owed_reg      <= 7'd0;
        ev_reg        <= EV_ERROR;
        ev_sig_reg    <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            active_reg <= 1'b0;
            bit_reg    <= 1'b0;
            if (i_start) begin
              if (i_len >= 7'd2) begin
                state_reg     <= S_PRE;
                len_reg       <= i_len;
                owed_reg      <= i_len - 7'd2;
                crc_reg       <= CRC_INIT;
                hold_full_reg <= 1'b0;
                clk_cnt_reg   <= 16'd0;
                idx_reg       <= 4'd0;
                active_reg    <= 1'b1;
                bit_reg       <= PREAMBLE[0];
                tick_reg      <= 1'b1;
              end else begin
                ev_reg     <= EV_ERROR;
                ev_sig_reg <= 1'b1;
              end
            end
          end

          S_DONE: begin
            state_reg <= S_IDLE;
          end

          default: begin
            if (!bit_last) begin
              clk_cnt_reg <= clk_cnt_reg + 16'd1;
            end else begin
              clk_cnt_reg <= 16'd0;
              tick_reg    <= 1'b1;
              if (idx_reg != last_idx) begin
                idx_reg <= idx_inc;
                bit_reg <= next_bit;
              end else begin
                idx_reg <= 4'd0;
                case (state_reg)
                  S_PRE: begin
                    state_reg  <= S_SFD;
                    bit_reg    <= SFD[0];
                    ev_reg     <= EV_PREAMBLE;
                    ev_sig_reg <= 1'b1;
                  end
                  S_SFD: begin
                    state_reg  <= S_PHR;
                    bit_reg    <= len_reg[0];
                    ev_reg     <= EV_SFD;
                    ev_sig_reg <= 1'b1;
                  end
                  S_PHR, S_PSDU: begin
                    // Byte boundary: next PSDU byte must already be held, else underrun.
                    if (hold_full_reg) begin
                      state_reg     <= S_PSDU;
                      cur_reg       <= hold_reg;
                      hold_full_reg <= 1'b0;
                      bit_reg       <= hold_reg[0];
                      if (state_reg == S_PSDU) begin
                        ev_reg     <= EV_BYTE;
                        ev_sig_reg <= 1'b1;
                      end
                    end else if (owed_reg == 7'd0) begin
                      state_reg <= S_FCS;
                      fcs_reg   <= crc_reg;
                      bit_reg   <= crc_reg[0];
                      if (state_reg == S_PSDU) begin
                        ev_reg     <= EV_BYTE;
                        ev_sig_reg <= 1'b1;
                      end
                    end else begin
                      state_reg  <= S_IDLE;
                      active_reg <= 1'b0;
                      bit_reg    <= 1'b0;
                      tick_reg   <= 1'b0;
                      ev_reg     <= EV_ERROR;
                      ev_sig_reg <= 1'b1;
                    end
                  end
                  S_FCS: begin
                    state_reg  <= S_DONE;
                    active_reg <= 1'b0;
                    bit_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                    ev_reg     <= EV_COMPLETE;
                    ev_sig_reg <= 1'b1;
                  end
                  default: begin
                    state_reg <= S_IDLE;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  // Abort forces the line quiet in the very cycle it is seen.
  assign o_byte_ready = ready;
  assign o_bit        = bit_reg && !abort;
  assign o_bit_tick   = tick_reg && !abort;
  assign o_tx_active  = active_reg && !abort;
  assign o_ev_sig     = ev_sig_reg || abort;
  assign o_ev         = abort ? EV_ERROR : ev_reg;

endmodule

// File: tb/tb_sym_frame_enc.sv
// Self-checking bench for sym_frame_enc: table of frame scenarios, randomized frames,
// and hand-written reset/abort sequences, all checked against a bit-level frame model.

module tb_sym_frame_enc;

  localparam logic [7:0] PRE_PAT = 8'h55;
  localparam logic [7:0] SFD_PAT = 8'hA7;
  localparam int         BCLK    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic [6:0] i_len = 7'd0;
  logic [7:0] i_byte = 8'd0;
  logic       i_byte_valid = 1'b0;
  logic       o_byte_ready, o_bit, o_bit_tick, o_tx_active, o_ev_sig;
  logic [2:0] o_ev;
`ifdef SYM_ENC_ABORT_EN
  logic       i_abort = 1'b0;
`endif

  sym_frame_enc #(.BIT_CLKS(16'd4), .PREAMBLE(PRE_PAT), .SFD(SFD_PAT)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_len(i_len),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid),
`ifdef SYM_ENC_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_byte_ready(o_byte_ready), .o_bit(o_bit), .o_bit_tick(o_bit_tick),
    .o_tx_active(o_tx_active), .o_ev(o_ev), .o_ev_sig(o_ev_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    bit withhold;
    bit poke;
    bit fixed;
    int exp_active;
    int exp_nev;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  bit         got_bits[$];
  bit         exp_bits[$];
  int         got_ev[$];
  int         exp_ev[$];
  logic [7:0] pay[$];
  logic [7:0] feed_q[$];
  int         act_cnt;
  bit         ready_seen;
  bit         mon_en = 1'b0;
  bit         xfer_pend = 1'b0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: one sample per clock, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_bit_tick) got_bits.push_back(o_bit);
      if (o_tx_active) act_cnt++;
      if (o_ev_sig) got_ev.push_back(int'(o_ev));
      if (o_byte_ready) ready_seen = 1'b1;
    end
  end

  // MAC-side byte source with random stalls.
  always @(negedge clk) begin
    if (xfer_pend && feed_q.size() > 0) feed_q.delete(0);
    i_byte_valid = (feed_q.size() > 0) && ($urandom_range(0, 3) != 0);
    i_byte       = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    xfer_pend    = i_byte_valid && o_byte_ready;
  end

  // Reference frame: fields listed in transmit order, CRC computed over the payload bits.
  task automatic build_exp(input int len, input bit under);
    logic [15:0] crc;
    bit          b;
    exp_bits.delete();
    exp_ev.delete();
    if (len < 2) begin
      exp_ev.push_back(5);
      return;
    end
    for (int i = 0; i < 8; i++) exp_bits.push_back(PRE_PAT[i]);
    for (int i = 0; i < 8; i++) exp_bits.push_back(SFD_PAT[i]);
    for (int i = 0; i < 8; i++) exp_bits.push_back((i < 7) ? bit'((len >> i) & 1) : 1'b0);
    exp_ev.push_back(1);
    exp_ev.push_back(2);
    if (under) begin
      exp_ev.push_back(5);
      return;
    end
    crc = 16'hFFFF;
    foreach (pay[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = pay[k][i];
        exp_bits.push_back(b);
        crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
      end
      exp_ev.push_back(3);
    end
    for (int i = 0; i < 16; i++) exp_bits.push_back(crc[i]);
    exp_ev.push_back(4);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit done;
    bit under;
    int mism;
    logic [15:0] seen;
    under = v.withhold && (v.len > 2);
    pay.delete();
    if (v.fixed) begin
      pay.push_back(8'hA5);
      pay.push_back(8'h3C);
    end else begin
      for (int k = 0; k < v.len - 2; k++) pay.push_back(8'($urandom));
    end
    build_exp(v.len, under);
    got_bits.delete();
    got_ev.delete();
    act_cnt = 0;
    ready_seen = 1'b0;

    @(negedge clk);
    feed_q.delete();
    if (!v.withhold) foreach (pay[k]) feed_q.push_back(pay[k]);
    i_start = 1'b1;
    i_len   = 7'(v.len);
    mon_en  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (v.len >= 2)
      check({tag, " start_latency"}, o_tx_active && o_bit_tick && (o_bit == PRE_PAT[0]),
            {o_tx_active, o_bit_tick, o_bit}, {3'b110 | {2'b00, PRE_PAT[0]}});
    else
      check({tag, " short_len_inactive"}, !o_tx_active, o_tx_active, 0);

    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (o_ev_sig && (o_ev == 3'd4 || o_ev == 3'd5)) begin
        done = 1'b1;
      end else begin
        if (v.poke && c == 20) begin
          i_start = 1'b1;
          i_len   = 7'd9;
        end
        @(negedge clk);
        i_start = 1'b0;
      end
    end
    check({tag, " frame_end_seen"}, done, done, 1);
    @(negedge clk);
    mon_en = 1'b0;

    check({tag, " active_cycles"}, act_cnt == v.exp_active, act_cnt, v.exp_active);
    check({tag, " event_count"}, got_ev.size() == v.exp_nev, got_ev.size(), v.exp_nev);
    mism = -1;
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      if (mism < 0 && got_ev[i] != exp_ev[i]) mism = i;
    check({tag, " event_codes"}, mism < 0 && got_ev.size() == exp_ev.size(), mism, -1);
    check({tag, " bit_count"}, got_bits.size() == exp_bits.size(), got_bits.size(), exp_bits.size());
    mism = -1;
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      if (mism < 0 && got_bits[i] != exp_bits[i]) mism = i;
    check({tag, " bit_content"}, mism < 0, mism, -1);
    check({tag, " byte_ready_seen"}, ready_seen == (v.len > 2), ready_seen, int'(v.len > 2));

    // Literal expectations for the fixed-payload and empty-PSDU frames.
    if ((v.fixed || v.len == 2) && !v.withhold && got_bits.size() >= 40) begin
      seen = '0;
      for (int i = 0; i < 16; i++) seen[i] = got_bits[24 + i];
      if (v.fixed) check({tag, " psdu_bits_A5_3C"}, seen == 16'h3CA5, seen, 16'h3CA5);
      else         check({tag, " fcs_is_crc_init"}, seen == 16'hFFFF, seen, 16'hFFFF);
    end
    repeat (3) @(negedge clk);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   wait_c;

  initial begin
    tbl[0] = '{len: 2,   withhold: 0, poke: 0, fixed: 0, exp_active: 160,  exp_nev: 3};
    tbl[1] = '{len: 4,   withhold: 0, poke: 0, fixed: 1, exp_active: 224,  exp_nev: 5};
    tbl[2] = '{len: 4,   withhold: 1, poke: 0, fixed: 0, exp_active: 96,   exp_nev: 3};
    tbl[3] = '{len: 1,   withhold: 0, poke: 0, fixed: 0, exp_active: 0,    exp_nev: 1};
    tbl[4] = '{len: 2,   withhold: 0, poke: 1, fixed: 0, exp_active: 160,  exp_nev: 3};
    tbl[5] = '{len: 0,   withhold: 0, poke: 0, fixed: 0, exp_active: 0,    exp_nev: 1};
    tbl[6] = '{len: 3,   withhold: 0, poke: 0, fixed: 0, exp_active: 192,  exp_nev: 4};
    tbl[7] = '{len: 127, withhold: 0, poke: 0, fixed: 0, exp_active: 4160, exp_nev: 128};

    repeat (3) @(negedge clk);
    check("reset_outputs", {o_tx_active, o_bit, o_bit_tick, o_byte_ready, o_ev_sig, o_ev} == 8'd0,
          {o_tx_active, o_bit, o_bit_tick, o_byte_ready, o_ev_sig, o_ev}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    for (int r = 0; r < 6; r++) begin
      rv.len        = $urandom_range(2, 24);
      rv.withhold   = 1'b0;
      rv.poke       = 1'b0;
      rv.fixed      = 1'b0;
      rv.exp_active = (8 * rv.len + 24) * BCLK;
      rv.exp_nev    = rv.len + 1;
      run_vec(rv, $sformatf("rand%0d_len%0d", r, rv.len));
    end

    // Asynchronous reset in the middle of the PSDU.
    @(negedge clk);
    feed_q.delete();
    for (int k = 0; k < 4; k++) feed_q.push_back(8'($urandom));
    i_start = 1'b1;
    i_len   = 7'd6;
    @(negedge clk);
    i_start = 1'b0;
    wait_c = 0;
    while (wait_c < 24 * BCLK + 20) begin
      @(negedge clk);
      wait_c++;
    end
    check("pre_reset_active", o_tx_active, o_tx_active, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {o_tx_active, o_bit, o_bit_tick, o_byte_ready, o_ev_sig, o_ev} == 8'd0,
          {o_tx_active, o_bit, o_bit_tick, o_byte_ready, o_ev_sig, o_ev}, 0);
    @(negedge clk);
    reset = 1'b0;
    feed_q.delete();
    repeat (3) @(negedge clk);
    run_vec(tbl[1], "after_reset");

`ifdef SYM_ENC_ABORT_EN
    // Abort while the SFD is on the line.
    @(negedge clk);
    i_start = 1'b1;
    i_len   = 7'd2;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8 * BCLK + 6) @(negedge clk);
    i_abort = 1'b1;
    #1;
    check("abort_error", !o_tx_active && o_ev_sig && (o_ev == 3'd5),
          {o_tx_active, o_ev_sig, o_ev}, 5'b01101);
    @(negedge clk);
    i_abort = 1'b0;
    repeat (BCLK * 2) @(negedge clk);
    check("abort_idle", !o_tx_active && !o_bit_tick, {o_tx_active, o_bit_tick}, 0);
    run_vec(tbl[0], "after_abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
